// File: rtl/pwm_ramp_ctrl_if.sv
// Configuration handshake bundle for pwm_ramp_ctrl.
// The master offers a configuration; the slave (the ramp controller) accepts it.
interface pwm_ramp_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic [WIDTH-1:0] cfg_duty;
   logic [WIDTH-1:0] cfg_period;
   logic [WIDTH-1:0] cfg_step;
   logic [WIDTH-1:0] cfg_interval;

   modport master (
      output cfg_valid,
      output cfg_duty,
      output cfg_period,
      output cfg_step,
      output cfg_interval,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_duty,
      input  cfg_period,
      input  cfg_step,
      input  cfg_interval,
      output cfg_ready
   );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// PWM duty/period ramp controller.
// Accepts a configuration in IDLE, waits for a PWM rollover to apply the new
// period (clamping duty into it), then walks duty toward the target by a
// fixed step every 'interval' rollovers. All output changes land on rollover
// edges so the PWM core never sees a mid-period update.
module pwm_ramp_ctrl #(
   parameter int WIDTH        = 8,
   parameter int RESET_PERIOD = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   pwm_ramp_ctrl_if.slave   cfg,
   input  logic             rollover,
   output logic [WIDTH-1:0] duty_out,
   output logic [WIDTH-1:0] period_out,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SYNC = 2'd1,
      RAMP = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] duty_reg, duty_next;
   logic [WIDTH-1:0] period_reg, period_next;
   logic [WIDTH-1:0] target_reg, target_next;
   logic [WIDTH-1:0] step_reg, step_next;
   logic [WIDTH-1:0] interval_reg, interval_next;
   logic [WIDTH-1:0] sh_period_reg, sh_period_next;
   logic [WIDTH-1:0] cnt_reg, cnt_next;
   logic             done_reg, done_next;

   // Datapath helpers used by the next-state logic.
   logic [WIDTH-1:0] clamp_duty;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] step_duty;
   logic [WIDTH-1:0] cnt_inc;

   assign clamp_duty = (duty_reg < sh_period_reg) ? duty_reg : sh_period_reg;
   // Larger minus smaller so the distance never wraps.
   assign diff       = (duty_reg > target_reg) ? (duty_reg - target_reg)
                                               : (target_reg - duty_reg);
   // Snap to target when within one step (or step is zero) to avoid overshoot.
   assign step_duty  = ((step_reg == '0) || (diff <= step_reg)) ? target_reg :
                       (duty_reg > target_reg) ? (duty_reg - step_reg)
                                               : (duty_reg + step_reg);
   assign cnt_inc    = cnt_reg + WIDTH'(1);

   // State and data registers; reset dominates everything else.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         duty_reg      <= '0;
         period_reg    <= WIDTH'(RESET_PERIOD);
         target_reg    <= '0;
         step_reg      <= '0;
         interval_reg  <= '0;
         sh_period_reg <= '0;
         cnt_reg       <= '0;
         done_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         duty_reg      <= duty_next;
         period_reg    <= period_next;
         target_reg    <= target_next;
         step_reg      <= step_next;
         interval_reg  <= interval_next;
         sh_period_reg <= sh_period_next;
         cnt_reg       <= cnt_next;
         done_reg      <= done_next;
      end
   end

   // Next-state and next-data decode; a rollover in IDLE is deliberately ignored,
   // as is a rollover arriving on the same edge as a transfer.
   always_comb begin
      state_next     = state_reg;
      duty_next      = duty_reg;
      period_next    = period_reg;
      target_next    = target_reg;
      step_next      = step_reg;
      interval_next  = interval_reg;
      sh_period_next = sh_period_reg;
      cnt_next       = cnt_reg;
      done_next      = 1'b0;

      case (state_reg)
         IDLE: begin
            if (cfg.cfg_valid) begin
               sh_period_next = cfg.cfg_period;
               step_next      = cfg.cfg_step;
               interval_next  = (cfg.cfg_interval == '0) ? WIDTH'(1) : cfg.cfg_interval;
               target_next    = (cfg.cfg_duty < cfg.cfg_period) ? cfg.cfg_duty : cfg.cfg_period;
               cnt_next       = '0;
               state_next     = SYNC;
            end
         end
         SYNC: begin
            if (rollover) begin
               period_next = sh_period_reg;
               duty_next   = clamp_duty;
               cnt_next    = '0;
               if (clamp_duty == target_reg) begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end else begin
                  state_next = RAMP;
               end
            end
         end
         RAMP: begin
            if (rollover) begin
               if (cnt_inc == interval_reg) begin
                  cnt_next  = '0;
                  duty_next = step_duty;
                  if (step_duty == target_reg) begin
                     state_next = IDLE;
                     done_next  = 1'b1;
                  end
               end else begin
                  cnt_next = cnt_inc;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign cfg.cfg_ready = (state_reg == IDLE);
   assign busy          = (state_reg != IDLE);
   assign duty_out      = duty_reg;
   assign period_out    = period_reg;
   assign done          = done_reg;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed testbench for pwm_ramp_ctrl with hand-computed expected values.
module tb_pwm_ramp_ctrl;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             rollover;
   logic [WIDTH-1:0] duty_out;
   logic [WIDTH-1:0] period_out;
   logic             busy;
   logic             done;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int done_base;

   pwm_ramp_ctrl_if #(.WIDTH(WIDTH)) cfg_if ();

   pwm_ramp_ctrl #(.WIDTH(WIDTH), .RESET_PERIOD(255)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg        (cfg_if.slave),
      .rollover   (rollover),
      .duty_out   (duty_out),
      .period_out (period_out),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // Count done pulses; sampled at the active edge, so the count reflects the prior cycle.
   always @(posedge clk) begin
      if (done === 1'b1) done_cnt++;
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // One-cycle rollover pulse; returns at the negedge after the capturing edge.
   task automatic roll();
      @(negedge clk);
      rollover = 1'b1;
      @(negedge clk);
      rollover = 1'b0;
   endtask

   task automatic roll_check(input string tag, input int exp_duty, input int exp_period);
      roll();
      check_eq({tag, "_duty"}, 32'(duty_out), 32'(exp_duty));
      check_eq({tag, "_period"}, 32'(period_out), 32'(exp_period));
      $display("rollover %s: duty=%0d period=%0d busy=%0b done=%0b", tag, duty_out, period_out, busy, done);
   endtask

   // Offer a configuration for one cycle, optionally with a coincident rollover.
   task automatic send_cfg(input int d, input int p, input int s, input int iv, input bit with_roll);
      @(negedge clk);
      cfg_if.cfg_valid    = 1'b1;
      cfg_if.cfg_duty     = 8'(d);
      cfg_if.cfg_period   = 8'(p);
      cfg_if.cfg_step     = 8'(s);
      cfg_if.cfg_interval = 8'(iv);
      rollover            = with_roll;
      @(negedge clk);
      cfg_if.cfg_valid = 1'b0;
      rollover         = 1'b0;
      $display("cfg duty=%0d period=%0d step=%0d interval=%0d roll=%0b", d, p, s, iv, with_roll);
   endtask

   int exp30 [8] = '{0, 25, 25, 50, 50, 75, 75, 100};

   initial begin
      rst_n               = 1'b0;
      rollover            = 1'b0;
      cfg_if.cfg_valid    = 1'b0;
      cfg_if.cfg_duty     = '0;
      cfg_if.cfg_period   = '0;
      cfg_if.cfg_step     = '0;
      cfg_if.cfg_interval = '0;
      idle_cycles(3);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("rst_duty", 32'(duty_out), 0);
      check_eq("rst_period", 32'(period_out), 255);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_ready", 32'(cfg_if.cfg_ready), 1);
      check_eq("rst_done", 32'(done), 0);

      // Slow ramp up: step 25 every 2 rollovers, with an ignored offer mid-ramp.
      done_base = done_cnt;
      send_cfg(100, 200, 25, 2, 1'b0);
      check_eq("a_busy", 32'(busy), 1);
      check_eq("a_ready", 32'(cfg_if.cfg_ready), 0);
      roll_check("a_r1", 0, 200);
      for (int r = 2; r <= 9; r++) begin
         roll_check($sformatf("a_r%0d", r), exp30[r-2], 200);
         if (r == 4) begin
            check_eq("a_ready_ramp", 32'(cfg_if.cfg_ready), 0);
            send_cfg(5, 20, 1, 1, 1'b0);
         end
      end
      check_eq("a_done", 32'(done), 1);
      @(negedge clk);
      check_eq("a_done_low", 32'(done), 0);
      check_eq("a_busy_low", 32'(busy), 0);
      idle_cycles(2);
      check_eq("a_done_cnt", 32'(done_cnt - done_base), 1);

      // Ramp down with no undershoot.
      done_base = done_cnt;
      send_cfg(10, 200, 40, 1, 1'b0);
      roll_check("b_r1", 100, 200);
      roll_check("b_r2", 60, 200);
      roll_check("b_r3", 20, 200);
      roll_check("b_r4", 10, 200);
      check_eq("b_done", 32'(done), 1);
      idle_cycles(2);
      check_eq("b_busy", 32'(busy), 0);
      check_eq("b_done_cnt", 32'(done_cnt - done_base), 1);

      // Jump to 150, then shrink period below duty to exercise the clamp.
      send_cfg(150, 200, 0, 0, 1'b0);
      roll_check("c_r1", 10, 200);
      roll_check("c_r2", 150, 200);
      idle_cycles(2);
      done_base = done_cnt;
      send_cfg(30, 50, 0, 0, 1'b0);
      roll_check("c_r3", 50, 50);
      check_eq("c_busy_mid", 32'(busy), 1);
      roll_check("c_r4", 30, 50);
      check_eq("c_done", 32'(done), 1);
      idle_cycles(2);
      check_eq("c_done_cnt", 32'(done_cnt - done_base), 1);

      // Target clamped to period: 250 requested, 100 period.
      send_cfg(250, 100, 50, 1, 1'b0);
      roll_check("d_r1", 30, 100);
      roll_check("d_r2", 80, 100);
      roll_check("d_r3", 100, 100);
      check_eq("d_done", 32'(done), 1);
      idle_cycles(2);

      // Rollover in IDLE has no effect.
      roll_check("e_idle", 100, 100);
      check_eq("e_idle_busy", 32'(busy), 0);

      // Rollover coincident with the transfer is ignored; the next one applies.
      send_cfg(60, 150, 0, 1, 1'b1);
      check_eq("e_coinc_duty", 32'(duty_out), 100);
      check_eq("e_coinc_period", 32'(period_out), 100);
      check_eq("e_coinc_busy", 32'(busy), 1);
      roll_check("e_r1", 100, 150);
      roll_check("e_r2", 60, 150);
      check_eq("e_done", 32'(done), 1);
      idle_cycles(2);

      // Reset in the middle of a ramp at duty 50.
      done_base = done_cnt;
      send_cfg(0, 150, 10, 1, 1'b0);
      roll_check("f_r1", 60, 150);
      roll_check("f_r2", 50, 150);
      check_eq("f_busy_pre", 32'(busy), 1);
      rst_n = 1'b0;
      @(negedge clk);
      check_eq("f_rst_duty", 32'(duty_out), 0);
      check_eq("f_rst_period", 32'(period_out), 255);
      check_eq("f_rst_busy", 32'(busy), 0);
      check_eq("f_rst_ready", 32'(cfg_if.cfg_ready), 1);
      check_eq("f_rst_done", 32'(done), 0);
      rst_n = 1'b1;
      idle_cycles(3);
      check_eq("f_done_cnt", 32'(done_cnt - done_base), 0);
      roll_check("f_idle", 0, 255);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
